fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage directly upstream of the instruction decode LUT. Holds the program counter, issues reads to program memory with a wait-state-tolerant req/ack handshake, and captures the returned word in an instruction register. Presents the full word plus pre-split opcode and operand fields to decode and execute. Applies the decode stage's `pcInMux_ctrl` selection when the current instruction is accepted.

## Interface

Parameters:
- `AW`, 12: program address width.
- `STACK_DEPTH`, 4: hardware return-stack entries. Used only with `FETCH_STACK_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `pm_addr`  out  AW  program memory address.
- `pm_req`  out  1  read request.
- `pm_rdata`  in  16  read data; valid in the cycle `pm_ack`=1.
- `pm_ack`  in  1  read complete.
- `instruction`  out  16  instruction register (IR).
- `OP_dk`  out  8  IR[15:8].
- `OP_s`  out  4  IR[15:12].
- `ind`  out  1  IR[7], indirect-addressing flag.
- `dma`  out  7  IR[6:0], direct memory address.
- `k`  out  8  IR[7:0], short immediate.
- `instr_valid`  out  1  IR holds an unconsumed instruction.
- `instr_ready`  in  1  decode/execute accepts IR this cycle.
- `pcInMux_ctrl`  in  2  next-PC select, sampled on accept: 00 `branch_target`, 01 `acc_low`, 10 stack pop, 11 PC+1.
- `branch_target`  in  AW  branch destination.
- `acc_low`  in  AW  accumulator low bits (computed branch).
- `pc_push`  in  1  call: push PC+1 on accept.
- `pc`  out  AW  address of the instruction in IR.
- `stack_err`  out  1  sticky stack overflow or underflow flag.

## Operation

- The FSM has three states: IDLE, FETCH and HOLD.
- IDLE: entered on reset.
  - Goes to FETCH on the next cycle with `pm_addr`=0.
- FETCH: `pm_req`=1 and `pm_addr` is held stable.
  - On `pm_ack`=1: IR←`pm_rdata`, `pc`←`pm_addr`, go to HOLD.
  - Wait states are unbounded; `pm_req` stays high until ack.
- HOLD: `instr_valid`=1 and `pm_req`=0.
  - On `instr_ready`=1 (accept): load the next PC by `pcInMux_ctrl`, drive `pm_addr` with it, go to FETCH.
  - Without `instr_ready`, IR and `pc` hold indefinitely.
- `pcInMux_ctrl` and `pc_push` are ignored outside an accept.
- Field outputs are pure slices of IR.
- PC+1 wraps modulo 2^AW, so 2^AW−1 → 0.
- An acknowledgement seen outside FETCH is ignored.

## Timing

- Reset values:
  - `pm_addr`, `pm_req`, `instruction`, all field outputs, `instr_valid`, `pc`, `stack_err` are 0.
  - The stack is empty.
- Reset asserted mid-fetch: `pm_req`=0 on the next edge, and the in-flight ack is dropped.
- Zero-wait memory:
  - req asserted cycle N, ack at N.
  - `instr_valid`=1 at N+1.
  - If accepted at N+1, `pm_req`=1 with the new address at N+2.
  - Peak throughput is one instruction per 2 cycles.
- Each wait state adds one cycle.
- `instr_valid` falls in the cycle after accept.

## Configuration

- `FETCH_STACK_EN` defined: the return stack is compiled in, `STACK_DEPTH` entries of AW bits.
- On accept with `pc_push`=1:
  - PC+1 is pushed.
  - Push when full discards the deepest entry and sets `stack_err`.
- On accept with `pcInMux_ctrl`=10:
  - The top entry is popped into PC.
  - Pop when empty loads PC+1 and sets `stack_err`.
- Pop and push in the same accept: the pop is applied first, then the push, so the top is replaced and depth is unchanged.
- `stack_err` clears only on reset.
- `FETCH_STACK_EN` undefined:
  - No stack storage.
  - `pcInMux_ctrl`=10 behaves as 11.
  - `pc_push` is ignored.
  - `stack_err` is tied to 0.

## Test plan

- Reset then zero-wait memory returning 16'h7F88 at addr 0, `instr_ready`=1:
  - `pm_req` at cycle 1.
  - `instruction`=16'h7F88, `OP_dk`=8'h7F, `OP_s`=4'h7, `pc`=0, `instr_valid`=1 at cycle 2.
  - Next `pm_addr`=1.
- Ack delayed 3 cycles: `pm_req` and `pm_addr` stay stable for all 4 cycles; IR updates only after ack.
- `instr_ready`=0 for 5 cycles in HOLD: IR, `pc` and `instr_valid` are unchanged and `pm_req`=0; accept with `pcInMux_ctrl`=00, `branch_target`=12'h123 gives `pm_addr`=12'h123.
- PC=12'hFFF accepted with 11: `pm_addr`=0.
- With `FETCH_STACK_EN`:
  - Call at PC 5 (`pc_push`=1, target 12'h040), then a return: fetch at 6.
  - 5 nested pushes: `stack_err`=1.
  - Pop on empty: next PC=PC+1 and `stack_err`=1.
- Without `FETCH_STACK_EN`: select 10 at PC 9 fetches 10 (12'h00A), and `stack_err` stays 0.
- `rst_n`=0 during a FETCH wait: `pm_req`=0 on the next edge.
  - An ack arriving later is ignored.
  - After release the fetch restarts at address 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack program-memory reads, instruction register and field split.
// Optional return stack compiled in with `define FETCH_STACK_EN.
module fetch_unit #(
  parameter int unsigned AW          = 12,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] pm_addr,
  output logic          pm_req,
  input  logic [15:0]   pm_rdata,
  input  logic          pm_ack,
  output logic [15:0]   instruction,
  output logic [7:0]    OP_dk,
  output logic [3:0]    OP_s,
  output logic          ind,
  output logic [6:0]    dma,
  output logic [7:0]    k,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic [1:0]    pcInMux_ctrl,
  input  logic [AW-1:0] branch_target,
  input  logic [AW-1:0] acc_low,
  input  logic          pc_push,
  output logic [AW-1:0] pc,
  output logic          stack_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr_nx;
  logic [AW-1:0] pc_nx;
  logic [15:0]   ir_nx;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pop_val;
  logic [AW-1:0] pc_sel;
  logic          accept;

  assign accept = (state == HOLD) && instr_ready;
  assign pc_inc = pc + AW'(1);

  // Decode fields are plain slices of the registered IR
  assign OP_dk = instruction[15:8];
  assign OP_s  = instruction[15:12];
  assign ind   = instruction[7];
  assign dma   = instruction[6:0];
  assign k     = instruction[7:0];

  // Next-PC select applied on accept
  always_comb begin
    pc_sel = pc_inc;
    case (pcInMux_ctrl)
      2'b00:   pc_sel = branch_target;
      2'b01:   pc_sel = acc_low;
      2'b10:   pc_sel = pop_val;
      default: pc_sel = pc_inc;
    endcase
  end

  // Next-state and datapath loads
  always_comb begin
    state_nx = state;
    addr_nx  = pm_addr;
    ir_nx    = instruction;
    pc_nx    = pc;
    case (state)
      IDLE: begin
        state_nx = FETCH;
        addr_nx  = '0;
      end
      FETCH: begin
        if (pm_ack) begin
          ir_nx    = pm_rdata;
          pc_nx    = pm_addr;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          addr_nx  = pc_sel;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pm_addr     <= '0;
      pm_req      <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= '0;
      pc          <= '0;
    end else begin
      state       <= state_nx;
      pm_addr     <= addr_nx;
      pm_req      <= (state_nx == FETCH);
      instr_valid <= (state_nx == HOLD);
      instruction <= ir_nx;
      pc          <= pc_nx;
    end
  end

`ifdef FETCH_STACK_EN
  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

  logic [AW-1:0] stk    [STACK_DEPTH];
  logic [AW-1:0] stk_nx [STACK_DEPTH];
  logic [SP_W-1:0] cnt, cnt_nx;
  logic            err_nx;

  // Entry 0 is the top; a push onto a full stack shifts the deepest entry out
  always_comb begin
    stk_nx  = stk;
    cnt_nx  = cnt;
    err_nx  = stack_err;
    pop_val = pc_inc;
    if (accept) begin
      if (pcInMux_ctrl == 2'b10) begin
        if (cnt == '0) begin
          err_nx = 1'b1;
        end else begin
          pop_val = stk[0];
          for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) stk_nx[i] = stk[i+1];
          stk_nx[STACK_DEPTH-1] = '0;
          cnt_nx = cnt - SP_W'(1);
        end
      end
      if (pc_push) begin
        for (int i = int'(STACK_DEPTH) - 1; i > 0; i--) stk_nx[i] = stk_nx[i-1];
        stk_nx[0] = pc_inc;
        if (cnt_nx == SP_W'(STACK_DEPTH)) err_nx = 1'b1;
        else                              cnt_nx = cnt_nx + SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) stk[i] <= '0;
      cnt       <= '0;
      stack_err <= 1'b0;
    end else begin
      stk       <= stk_nx;
      cnt       <= cnt_nx;
      stack_err <= err_nx;
    end
  end
`else
  logic unused;

  // Without the stack a pop falls back to sequential fetch
  assign pop_val   = pc_inc;
  assign stack_err = 1'b0;
  assign unused    = &{1'b0, pc_push, 1'(STACK_DEPTH)};
`endif

endmodule
